// File: rtl/lot_display_pkg.sv
// Shared types and active-low 7-segment glyphs for the parking-lot display.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package lot_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_D0    = 7'b1000000;
  localparam seg7_t SEG_D1    = 7'b1111001;
  localparam seg7_t SEG_D2    = 7'b0100100;
  localparam seg7_t SEG_D3    = 7'b0110000;
  localparam seg7_t SEG_D4    = 7'b0011001;
  localparam seg7_t SEG_D5    = 7'b0010010;
  localparam seg7_t SEG_D6    = 7'b0000010;
  localparam seg7_t SEG_D7    = 7'b1111000;
  localparam seg7_t SEG_D8    = 7'b0000000;
  localparam seg7_t SEG_D9    = 7'b0010000;
  localparam seg7_t SEG_C     = 7'b1000110;
  localparam seg7_t SEG_L     = 7'b1000111;
  localparam seg7_t SEG_E     = 7'b0000110;
  localparam seg7_t SEG_A     = 7'b0001000;
  localparam seg7_t SEG_R     = 7'b0101111;
  localparam seg7_t SEG_F     = 7'b0001110;
  localparam seg7_t SEG_U     = 7'b1000001;

endpackage

// File: rtl/lot_display_seg7_digit.sv
// Combinational BCD digit to active-low 7-segment glyph, with forced blank.
// Codes 10..15 are not BCD and render as blank.
module seg7_digit
  import lot_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output seg7_t      o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_D0;
        4'd1:    o_seg = SEG_D1;
        4'd2:    o_seg = SEG_D2;
        4'd3:    o_seg = SEG_D3;
        4'd4:    o_seg = SEG_D4;
        4'd5:    o_seg = SEG_D5;
        4'd6:    o_seg = SEG_D6;
        4'd7:    o_seg = SEG_D7;
        4'd8:    o_seg = SEG_D8;
        4'd9:    o_seg = SEG_D9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/lot_display_ctrl.sv
// Parking-lot occupancy counter kept in BCD, with CLEAR / FULL 7-segment display.
// Define LOT_FULL_BLINK_EN to make the FULL word blink every BLINK_DIV cycles.
module lot_display_ctrl
  import lot_display_pkg::*;
#(
  parameter int MAX_CARS  = 25,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       car_enter,
  input  logic       car_exit,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       full,
  output logic       empty,
  output logic       reject,
  output seg7_t      hexArray [5:0]
);

  // Capacity split into BCD digits once, at elaboration.
  localparam logic [3:0] MAX_ONES = 4'(MAX_CARS % 10);
  localparam logic [3:0] MAX_TENS = 4'(MAX_CARS / 10);

  if (MAX_CARS < 1 || MAX_CARS > 99 || BLINK_DIV < 2) begin : g_param_check
    $error("lot_display_ctrl: MAX_CARS must be 1..99 and BLINK_DIV >= 2");
  end

  logic       r_enter_q, r_exit_q;
  logic [3:0] r_ones, r_tens;
  logic       r_full, r_empty, r_reject;
  seg7_t      r_hex [5:0];

  logic       w_arr, w_dep, w_inc, w_dec, w_rej_next;
  logic [3:0] w_ones_next, w_tens_next;
  logic       w_full_next, w_empty_next, w_word_blank;
  seg7_t      w_tens_seg, w_ones_seg;
  seg7_t      w_hex_next [5:0];

  // Samples reset high so a sensor held through reset release is not an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enter_q <= 1'b1;
      r_exit_q  <= 1'b1;
    end else begin
      r_enter_q <= car_enter;
      r_exit_q  <= car_exit;
    end
  end

  assign w_arr      = car_enter & ~r_enter_q;
  assign w_dep      = car_exit & ~r_exit_q;
  assign w_inc      = w_arr & ~w_dep & ~r_full;
  assign w_dec      = w_dep & ~w_arr & ~r_empty;
  assign w_rej_next = (w_arr & ~w_dep & r_full) | (w_dep & ~w_arr & r_empty);

  always_comb begin
    w_ones_next = r_ones;
    w_tens_next = r_tens;
    if (w_inc) begin
      if (r_ones == 4'd9) begin
        w_ones_next = 4'd0;
        w_tens_next = r_tens + 4'd1;
      end else begin
        w_ones_next = r_ones + 4'd1;
      end
    end else if (w_dec) begin
      if (r_ones == 4'd0) begin
        w_ones_next = 4'd9;
        w_tens_next = r_tens - 4'd1;
      end else begin
        w_ones_next = r_ones - 4'd1;
      end
    end
  end

  assign w_full_next  = (w_ones_next == MAX_ONES) && (w_tens_next == MAX_TENS);
  assign w_empty_next = (w_ones_next == 4'd0) && (w_tens_next == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ones   <= 4'd0;
      r_tens   <= 4'd0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_reject <= 1'b0;
    end else begin
      r_ones   <= w_ones_next;
      r_tens   <= w_tens_next;
      r_full   <= w_full_next;
      r_empty  <= w_empty_next;
      r_reject <= w_rej_next;
    end
  end

`ifdef LOT_FULL_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  // Held at zero/visible while not full, so each full episode starts visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!r_full) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign w_word_blank = r_blink_phase;
`else
  assign w_word_blank = 1'b0;
`endif

  seg7_digit u_tens_digit (
    .i_bcd   (r_tens),
    .i_blank (r_tens == 4'd0),
    .o_seg   (w_tens_seg)
  );

  seg7_digit u_ones_digit (
    .i_bcd   (r_ones),
    .i_blank (1'b0),
    .o_seg   (w_ones_seg)
  );

  always_comb begin
    w_hex_next[5] = SEG_BLANK;
    w_hex_next[4] = SEG_BLANK;
    w_hex_next[3] = SEG_BLANK;
    w_hex_next[2] = SEG_BLANK;
    w_hex_next[1] = w_tens_seg;
    w_hex_next[0] = w_ones_seg;
    if (r_empty) begin
      w_hex_next[5] = SEG_C;
      w_hex_next[4] = SEG_L;
      w_hex_next[3] = SEG_E;
      w_hex_next[2] = SEG_A;
      w_hex_next[1] = SEG_R;
      w_hex_next[0] = SEG_D0;
    end else if (r_full && !w_word_blank) begin
      w_hex_next[5] = SEG_F;
      w_hex_next[4] = SEG_U;
      w_hex_next[3] = SEG_L;
      w_hex_next[2] = SEG_L;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex[5] <= SEG_C;
      r_hex[4] <= SEG_L;
      r_hex[3] <= SEG_E;
      r_hex[2] <= SEG_A;
      r_hex[1] <= SEG_R;
      r_hex[0] <= SEG_D0;
    end else begin
      r_hex <= w_hex_next;
    end
  end

  assign ones     = r_ones;
  assign tens     = r_tens;
  assign full     = r_full;
  assign empty    = r_empty;
  assign reject   = r_reject;
  assign hexArray = r_hex;

endmodule

// File: doc/lot_display_ctrl.md
LOT_DISPLAY_CTRL -- requirements
Module: lot_display_ctrl

Interface
REQ-001 Parameter MAX_CARS, default 25: lot capacity, legal range 1..99.
REQ-002 Parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period, legal range >= 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 car_enter  input  1  synchronous level from entry sensor; each rising edge is one arrival.
REQ-006 car_exit  input  1  synchronous level from exit sensor; each rising edge is one departure.
REQ-007 ones  output  4  BCD ones digit of occupancy.
REQ-008 tens  output  4  BCD tens digit of occupancy.
REQ-009 full  output  1  high while occupancy == MAX_CARS.
REQ-010 empty  output  1  high while occupancy == 0.
REQ-011 reject  output  1  one-cycle pulse on an ignored arrival or departure.
REQ-012 hexArray  output  6x7  registered active-low 7-segment patterns; index 5 = HEX5, index 0 = HEX0.

Function
REQ-013 Edge detect: each input is registered once; an event is input high while its previous-cycle sample is low; held-high levels count once.
REQ-014 Arrival only, occupancy < MAX_CARS: BCD increment at the next edge; ones 9 -> 0 carries into tens.
REQ-015 Departure only, occupancy > 0: BCD decrement at the next edge; ones 0 -> 9 borrows from tens.
REQ-016 Arrival and departure in the same cycle: occupancy unchanged, no reject.
REQ-017 Arrival at full, or departure at empty: occupancy unchanged, reject pulses high for exactly one cycle.
REQ-018 ones, tens, full and empty are registered and change at the same edge as the occupancy; no binary divide anywhere.
REQ-019 hexArray is a register loaded from the current occupancy, so it lags ones/tens by exactly one cycle.
REQ-020 Empty display: HEX5..HEX2 = C,L,E,A; HEX1 = R; HEX0 = 0.
REQ-021 Full display: HEX5..HEX2 = F,U,L,L; HEX1..HEX0 = tens/ones digits.
REQ-022 Otherwise: HEX5..HEX2 blank; HEX1 = tens digit, blanked when tens == 0; HEX0 = ones digit.
REQ-023 If MAX_CARS is 1 and the lot is full, the full display applies; empty has priority only at occupancy 0.

Reset
REQ-024 On reset_n low, asynchronously: ones = 0, tens = 0, empty = 1, full = 0, reject = 0, blink counter = 0, blink phase = visible.
REQ-025 On reset_n low, hexArray is set to the empty display.
REQ-026 Edge-detect samples reset to 1, so sensors held high through reset release produce no event.
REQ-027 Reset during a counting cycle discards the pending event.

Configuration
REQ-028 Macro LOT_FULL_BLINK_EN, when defined: while full, HEX5..HEX2 alternate between FULL and blank every BLINK_DIV cycles.
REQ-029 With LOT_FULL_BLINK_EN, the blink counter and phase clear on entering full, so the first visible phase lasts BLINK_DIV cycles.
REQ-030 With LOT_FULL_BLINK_EN, HEX1..HEX0 do not blink.
REQ-031 Without LOT_FULL_BLINK_EN: FULL is steady, and the blink counter logic is absent.

Structure
REQ-032 Package lot_display_pkg holds the 7-bit glyph constants: BLANK, digits 0-9, and letters C, L, E, A, R, F, U.
REQ-033 Package lot_display_pkg holds typedef seg7_t (logic [6:0]).
REQ-034 One sub-module, seg7_digit: combinational BCD-to-seg7_t with a blank input; non-BCD input gives BLANK.
REQ-035 lot_display_ctrl instantiates seg7_digit twice.

Verification (MAX_CARS=3, BLINK_DIV=4)
REQ-036 Reset release with car_enter held high -> no count, empty=1, hexArray = C,L,E,A,R,0.
REQ-037 Three enter pulses -> ones 1,2,3 with full=1 at the third edge; hexArray shows F,U,L,L,blank,3 one cycle later.
REQ-038 Fourth enter at full -> ones stays 3, reject high for one cycle; exit at empty -> reject pulse, ones stays 0.
REQ-039 Simultaneous enter and exit rising edges at occupancy 2 -> occupancy stays 2, reject = 0.
REQ-040 MAX_CARS=12, count 9 -> 10 -> 9: tens/ones go 0/9 -> 1/0 -> 0/9; HEX1 blank at 9 and shows 1 at 10.
REQ-041 LOT_FULL_BLINK_EN defined, full held for 16 cycles -> HEX5..HEX2 alternate FULL/blank every 4 cycles, HEX0 steady 3.
